// File: rtl/game_pkg.sv
// Shared game constants: character count, player index, direction codes and
// the move-scheduler state encoding.
package game_pkg;

    localparam int unsigned N_CHARS    = 5;
    localparam int unsigned IDX_PLAYER = 0;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_WAIT = 2'd2
    } sched_state_e;

endpackage

// File: rtl/step_gen.sv
// Move-step divider: one-cycle step every TICK_DIV clocks while enabled;
// pausing restarts the count from zero.
module step_gen #(
    parameter int unsigned TICK_DIV = 833333
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic step
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!enable || cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign step = enable && (cnt == CNT_MAX);

endmodule

// File: rtl/move_scheduler.sv
// Shares the single movement datapath among the player and ghosts: each move
// step snapshots all requests and issues them one at a time in index order.
module move_scheduler #(
    parameter  int unsigned N_CHARS  = game_pkg::N_CHARS,
    parameter  int unsigned TICK_DIV = 833333,
    localparam int unsigned IDX_W    = (N_CHARS > 1) ? $clog2(N_CHARS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_CHARS-1:0]   req_mv,
    input  logic [2*N_CHARS-1:0] req_dir,
    output logic                 upd_valid,
    input  logic                 upd_ready,
    output logic [IDX_W-1:0]     upd_idx,
    output logic [1:0]           upd_dir,
    output logic                 busy,
    output logic                 round_done,
    output logic                 overrun
);

    import game_pkg::*;

    sched_state_e              state, state_d;
    logic [N_CHARS-1:0]        pend, pend_d;
    logic [N_CHARS-1:0][1:0]   dir_snap, dir_snap_d;
    logic [IDX_W-1:0]          upd_idx_d, first_idx;
    logic [1:0]                upd_dir_d;
    logic                      upd_valid_d, round_done_d, overrun_d, busy_d;
    logic                      step;

    // Fixed priority: lowest set bit wins, so the player is always first.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_CHARS-1:0] v);
        logic found;
        lowest_set = '0;
        found      = 1'b0;
        for (int i = 0; i < N_CHARS; i++) begin
            if (v[i] && !found) begin
                lowest_set = IDX_W'(i);
                found      = 1'b1;
            end
        end
    endfunction

    step_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_step_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .step   (step)
    );

    always_comb begin
        state_d      = state;
        pend_d       = pend;
        dir_snap_d   = dir_snap;
        upd_valid_d  = upd_valid;
        upd_idx_d    = upd_idx;
        upd_dir_d    = upd_dir;
        round_done_d = 1'b0;
        overrun_d    = overrun;
        first_idx    = lowest_set(pend);

        // A step landing mid-round is dropped; only the sticky flag records it.
        if (step && state != S_IDLE) begin
            overrun_d = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (step) begin
                    pend_d     = req_mv;
                    dir_snap_d = req_dir;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!enable || pend == '0) begin
                    pend_d       = '0;
                    round_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    upd_idx_d         = first_idx;
                    upd_dir_d         = dir_snap[first_idx];
                    upd_valid_d       = 1'b1;
                    pend_d[first_idx] = 1'b0;
                    state_d           = S_WAIT;
                end
            end
            S_WAIT: begin
                if (upd_ready) begin
                    upd_valid_d = 1'b0;
                    state_d     = S_SCAN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pend       <= '0;
            dir_snap   <= '0;
            upd_valid  <= 1'b0;
            upd_idx    <= '0;
            upd_dir    <= '0;
            busy       <= 1'b0;
            round_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            pend       <= pend_d;
            dir_snap   <= dir_snap_d;
            upd_valid  <= upd_valid_d;
            upd_idx    <= upd_idx_d;
            upd_dir    <= upd_dir_d;
            busy       <= busy_d;
            round_done <= round_done_d;
            overrun    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: queue-based round model checked every cycle, plus
// directed scenarios with hand-computed service orders and timings.
module tb_move_scheduler;

    localparam int TD = 4;
    localparam int NC = 5;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [4:0] req_mv;
    logic [9:0] req_dir;
    logic       upd_valid;
    logic       upd_ready;
    logic [2:0] upd_idx;
    logic [1:0] upd_dir;
    logic       busy;
    logic       round_done;
    logic       overrun;

    move_scheduler #(
        .N_CHARS  (NC),
        .TICK_DIV (TD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_mv     (req_mv),
        .req_dir    (req_dir),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_idx    (upd_idx),
        .upd_dir    (upd_dir),
        .busy       (busy),
        .round_done (round_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a round is a queue of snapshotted characters; each service costs a
    // decision edge followed by the handshake edge.
    int m_cnt;
    bit m_round, m_scan, m_valid, m_rd, m_ovr;
    int m_idx, m_dir;
    int m_q[$];
    int m_snap[NC];

    always @(posedge clk or negedge reset) begin : model
        bit stp;
        if (!reset) begin
            m_cnt = 0; m_round = 0; m_scan = 0; m_valid = 0; m_rd = 0; m_ovr = 0;
            m_idx = 0; m_dir = 0;
            m_q.delete();
        end else begin
            stp   = enable && (m_cnt == TD - 1);
            m_cnt = (enable && m_cnt != TD - 1) ? m_cnt + 1 : 0;
            m_rd  = 0;
            if (!m_round) begin
                if (stp) begin
                    m_round = 1;
                    m_scan  = 1;
                    m_q.delete();
                    for (int i = 0; i < NC; i++) begin
                        if (req_mv[i]) begin
                            m_q.push_back(i);
                            m_snap[i] = int'(req_dir[2*i +: 2]);
                        end
                    end
                end
            end else begin
                if (stp) m_ovr = 1;
                if (m_valid) begin
                    if (upd_ready) begin
                        m_valid = 0;
                        m_scan  = 1;
                    end
                end else if (m_scan) begin
                    m_scan = 0;
                    if (!enable) m_q.delete();
                    if (m_q.size() == 0) begin
                        m_rd    = 1;
                        m_round = 0;
                    end else begin
                        m_idx   = m_q.pop_front();
                        m_dir   = m_snap[m_idx];
                        m_valid = 1;
                    end
                end
            end
        end
    end

    // Handshake log, taken at the edge where the transfer happens.
    int hs_idx[$];
    int hs_dir[$];
    always @(posedge clk) begin
        if (reset && upd_valid && upd_ready) begin
            hs_idx.push_back(int'(upd_idx));
            hs_dir.push_back(int'(upd_dir));
        end
    end

    int total = 0;
    int bad   = 0;
    int rd_count = 0;
    int valid_seen = 0;
    int hold1 = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("valid", int'(upd_valid), int'(m_valid));
        check("busy", int'(busy), int'(m_round));
        check("round_done", int'(round_done), int'(m_rd));
        check("overrun", int'(overrun), int'(m_ovr));
        if (m_valid) begin
            check("idx", int'(upd_idx), m_idx);
            check("dir", int'(upd_dir), m_dir);
        end
        if (round_done) rd_count++;
        if (upd_valid) valid_seen++;
        if (upd_valid && upd_idx == 3'd1 && upd_dir == 2'b11) hold1++;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
            compare_model();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; upd_ready = 1'b0; req_mv = '0;
        cycles(1);
        reset = 1'b1;
    endtask

    task automatic settle();
        enable = 1'b0; upd_ready = 1'b1;
        cycles(4);
    endtask

    int h0, rd0, v0, hold0;

    initial begin
        reset = 1'b0; enable = 1'b0; req_mv = '0; req_dir = '0; upd_ready = 1'b0;
        cycles(2);
        check("rst_valid", int'(upd_valid), 0);
        check("rst_idx", int'(upd_idx), 0);
        check("rst_dir", int'(upd_dir), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_round_done", int'(round_done), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b1;

        // 1: empty rounds
        enable = 1'b1; upd_ready = 1'b1;
        rd0 = rd_count; v0 = valid_seen; h0 = hs_idx.size();
        cycles(16);
        check("t1_rounds", rd_count - rd0, 3);
        check("t1_valid_seen", valid_seen - v0, 0);
        check("t1_hs", hs_idx.size() - h0, 0);
        check("t1_overrun", int'(overrun), 0);
        settle();

        // 2: sparse requests, ready tied high
        do_reset();
        req_mv = 5'b10101; req_dir = 10'b11_00_01_00_10; upd_ready = 1'b1; enable = 1'b1;
        h0 = hs_idx.size(); rd0 = rd_count;
        cycles(12);
        check("t2_hs_count", hs_idx.size() - h0, 3);
        if (hs_idx.size() - h0 == 3) begin
            check("t2_idx0", hs_idx[h0], 0);
            check("t2_idx1", hs_idx[h0+1], 2);
            check("t2_idx2", hs_idx[h0+2], 4);
            check("t2_dir0", hs_dir[h0], 2);
            check("t2_dir1", hs_dir[h0+1], 1);
            check("t2_dir2", hs_dir[h0+2], 3);
        end
        check("t2_rounds", rd_count - rd0, 1);
        check("t2_overrun", int'(overrun), 1);
        settle();

        // 3: backpressure holds idx/dir stable
        do_reset();
        req_mv = 5'b00011; req_dir = 10'b00_00_00_11_00; upd_ready = 1'b0; enable = 1'b1;
        h0 = hs_idx.size(); hold0 = hold1;
        cycles(5);
        upd_ready = 1'b1;
        cycles(1);
        upd_ready = 1'b0;
        cycles(4);
        upd_ready = 1'b1;
        cycles(1);
        upd_ready = 1'b0;
        check("t3_hs_count", hs_idx.size() - h0, 2);
        if (hs_idx.size() - h0 == 2) begin
            check("t3_idx0", hs_idx[h0], 0);
            check("t3_idx1", hs_idx[h0+1], 1);
            check("t3_dir1", hs_dir[h0+1], 3);
        end
        check("t3_hold_cycles", hold1 - hold0, 4);
        settle();

        // 4: request change mid-round is not seen
        do_reset();
        req_mv = 5'b00001; req_dir = 10'b0; upd_ready = 1'b1; enable = 1'b1;
        h0 = hs_idx.size(); rd0 = rd_count;
        cycles(4);
        req_mv = 5'b11111;
        cycles(4);
        check("t4_hs_count", hs_idx.size() - h0, 1);
        if (hs_idx.size() - h0 == 1) check("t4_idx0", hs_idx[h0], 0);
        check("t4_rounds", rd_count - rd0, 1);
        settle();

        // 5: overrun is sticky, dropped step never serviced
        do_reset();
        req_mv = 5'b00001; upd_ready = 1'b0; enable = 1'b1;
        h0 = hs_idx.size();
        cycles(8);
        check("t5_overrun_set", int'(overrun), 1);
        check("t5_busy", int'(busy), 1);
        upd_ready = 1'b1;
        cycles(1);
        enable = 1'b0; req_mv = '0;
        cycles(6);
        check("t5_overrun_sticky", int'(overrun), 1);
        check("t5_busy_after", int'(busy), 0);
        check("t5_hs_count", hs_idx.size() - h0, 1);

        // 6a: async reset during WAIT
        do_reset();
        req_mv = 5'b00011; req_dir = 10'b00_00_00_00_01; upd_ready = 1'b0; enable = 1'b1;
        cycles(6);
        check("t6_pre_valid", int'(upd_valid), 1);
        check("t6_pre_dir", int'(upd_dir), 1);
        reset = 1'b0;
        #1;
        check("t6_rst_valid", int'(upd_valid), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_dir", int'(upd_dir), 0);
        cycles(1);
        reset = 1'b1; enable = 1'b0;

        // 6b: pause mid-round completes the handshake then skips the rest
        do_reset();
        req_mv = 5'b00111; req_dir = 10'b00_00_10_01_11; upd_ready = 1'b0; enable = 1'b1;
        h0 = hs_idx.size(); rd0 = rd_count;
        cycles(5);
        enable = 1'b0; upd_ready = 1'b1;
        cycles(3);
        check("t6_hs_count", hs_idx.size() - h0, 1);
        if (hs_idx.size() - h0 == 1) begin
            check("t6_idx0", hs_idx[h0], 0);
            check("t6_dir0", hs_dir[h0], 3);
        end
        check("t6_rounds", rd_count - rd0, 1);
        check("t6_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
